// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pool window path.
package pool_pkg;

    localparam int DATA_W = 24;
    localparam int WIN_W  = 4 * DATA_W;

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef logic [WIN_W-1:0]         window_t;

    // Lane offsets inside a packed window.
    localparam int TL = 0;
    localparam int TR = DATA_W;
    localparam int BL = 2 * DATA_W;
    localparam int BR = 3 * DATA_W;

    // Packs four pixels into the window lane layout.
    function automatic window_t pack_window(input pixel_t tl, input pixel_t tr,
                                           input pixel_t bl, input pixel_t br);
        window_t w;
        w = '0;
        w[TL +: DATA_W] = tl;
        w[TR +: DATA_W] = tr;
        w[BL +: DATA_W] = bl;
        w[BR +: DATA_W] = br;
        return w;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Single-port synchronous RAM holding one row of top pixel pairs.
// Writes and reads happen on different rows, so they never collide.
module pool_line_buffer #(
    parameter int DEPTH  = 64,
    parameter int WORD_W = 48,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wr_data,
    output logic [WORD_W-1:0] o_rd_data
);

    // Storage is rounded up to a power of two so every address value is in range.
    localparam int MEM_DEPTH = (1 << ADDR_W);

    logic [WORD_W-1:0] r_mem [MEM_DEPTH];
    logic [WORD_W-1:0] r_rd_data;

    // Write port and registered read port sharing one address.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/maxpool_window_ctrl.sv
// Turns a raster pixel stream into non-overlapping 2x2 windows.
// Top row pairs are parked in a line buffer; on the odd row the stored
// pair is read back and merged with the current bottom pair.
module maxpool_window_ctrl
    import pool_pkg::*;
#(
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_pixel_data,
    input  logic              i_pixel_valid,
    output logic [WIN_W-1:0]  o_window_data,
    output logic              o_window_valid,
    output logic              o_frame_done,
    output logic              o_busy
);

    localparam int COL_W  = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W  = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
    localparam int DEPTH  = IMG_WIDTH / 2;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = 2 * DATA_W;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    // Position counters.
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;

    // Left element of the current pixel pair.
    pixel_t            r_held;

    // Line-buffer read tracking: r_rd_issued marks the cycle the RAM output
    // is fresh; r_rd_hold keeps it across valid gaps until it is consumed.
    logic              r_rd_issued;
    logic [WORD_W-1:0] r_rd_hold;
    logic              r_hold_vld;

    // Output registers.
    window_t           r_win_data;
    logic              r_win_vld;
    logic              r_frame_done;
    logic              r_busy;

    logic              w_col_last;
    logic              w_row_last;
    logic              w_col_odd;
    logic              w_row_odd;
    logic              w_col_in_pair;
    logic              w_row_in_pair;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_buf_avail;
    logic              w_win_fire;
    logic              w_last_pixel;
    logic [ADDR_W-1:0] w_addr;
    logic [WORD_W-1:0] w_wr_data;
    logic [WORD_W-1:0] w_rd_data;
    logic [WORD_W-1:0] w_buf_word;
    pixel_t            w_pixel;

    assign w_pixel    = pixel_t'(i_pixel_data);
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_col_odd  = r_col[0];
    assign w_row_odd  = r_row[0];

    // A trailing odd column or odd row has no partner and is only counted.
    assign w_col_in_pair = ((IMG_WIDTH  % 2) == 0) || !w_col_last;
    assign w_row_in_pair = ((IMG_HEIGHT % 2) == 0) || !w_row_last;

    assign w_last_pixel = w_col_last && w_row_last;

    // Top row: store {right, left} once the pair is complete.
    assign w_wr_en   = i_pixel_valid && !w_row_odd && w_col_odd && w_row_in_pair;
    assign w_wr_data = {w_pixel, r_held};

    // Bottom row: fetch the matching top pair on the left beat.
    assign w_rd_en   = i_pixel_valid && w_row_odd && !w_col_odd && w_col_in_pair;

    assign w_addr    = ADDR_W'(r_col >> 1);

    // RAM output is used directly when the right beat follows immediately,
    // otherwise the held copy is used.
    assign w_buf_avail = r_rd_issued || r_hold_vld;
    assign w_buf_word  = r_rd_issued ? w_rd_data : r_rd_hold;
    assign w_win_fire  = i_pixel_valid && w_row_odd && w_col_odd && w_buf_avail;

    pool_line_buffer #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_line_buffer (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_rd_en   (w_rd_en),
        .i_addr    (w_addr),
        .i_wr_data (w_wr_data),
        .o_rd_data (w_rd_data)
    );

    // Column/row counters; they advance only on valid beats and wrap per frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_pixel_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Capture the left pixel of each pair on even columns.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_held <= '0;
        end else if (i_pixel_valid && !w_col_odd) begin
            r_held <= w_pixel;
        end
    end

    // Track line-buffer read data and keep it until the right beat consumes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_issued <= 1'b0;
            r_rd_hold   <= '0;
            r_hold_vld  <= 1'b0;
        end else begin
            r_rd_issued <= w_rd_en;
            if (r_rd_issued) begin
                r_rd_hold <= w_rd_data;
            end
            if (w_win_fire) begin
                r_hold_vld <= 1'b0;
            end else if (r_rd_issued) begin
                r_hold_vld <= 1'b1;
            end
        end
    end

    // Register the completed window; data holds until the next window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win_data <= '0;
            r_win_vld  <= 1'b0;
        end else begin
            r_win_vld <= w_win_fire;
            if (w_win_fire) begin
                r_win_data <= pack_window(pixel_t'(w_buf_word[DATA_W-1:0]),
                                          pixel_t'(w_buf_word[WORD_W-1:DATA_W]),
                                          r_held,
                                          w_pixel);
            end
        end
    end

    // Frame status: done pulse after the last beat, busy while a frame is open.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= i_pixel_valid && w_last_pixel;
            if (i_pixel_valid) begin
                r_busy <= !w_last_pixel;
            end
        end
    end

    assign o_window_data  = r_win_data;
    assign o_window_valid = r_win_vld;
    assign o_frame_done   = r_frame_done;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Directed bench for maxpool_window_ctrl over several frame geometries.
module tb_maxpool_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data;
    logic [3:0]  vld;
    logic [95:0] wd [4];
    logic [3:0]  wv;
    logic [3:0]  fd;
    logic [3:0]  bz;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0: 4x4, instance 1: 5x3, instance 2: 4x2, instance 3: 2x2.
    maxpool_window_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_w4h4 (
        .i_clk(clk), .i_rst(rst), .i_pixel_data(data), .i_pixel_valid(vld[0]),
        .o_window_data(wd[0]), .o_window_valid(wv[0]), .o_frame_done(fd[0]), .o_busy(bz[0]));
    maxpool_window_ctrl #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) u_w5h3 (
        .i_clk(clk), .i_rst(rst), .i_pixel_data(data), .i_pixel_valid(vld[1]),
        .o_window_data(wd[1]), .o_window_valid(wv[1]), .o_frame_done(fd[1]), .o_busy(bz[1]));
    maxpool_window_ctrl #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) u_w4h2 (
        .i_clk(clk), .i_rst(rst), .i_pixel_data(data), .i_pixel_valid(vld[2]),
        .o_window_data(wd[2]), .o_window_valid(wv[2]), .o_frame_done(fd[2]), .o_busy(bz[2]));
    maxpool_window_ctrl #(.IMG_WIDTH(2), .IMG_HEIGHT(2)) u_w2h2 (
        .i_clk(clk), .i_rst(rst), .i_pixel_data(data), .i_pixel_valid(vld[3]),
        .o_window_data(wd[3]), .o_window_valid(wv[3]), .o_frame_done(fd[3]), .o_busy(bz[3]));

    function automatic logic [95:0] win(input int tl, input int tr, input int bl, input int br);
        return {br[23:0], bl[23:0], tr[23:0], tl[23:0]};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One valid beat to instance k; entered and left on a falling edge.
    task automatic beat(input int k, input logic [23:0] d);
        data   = d;
        vld    = 4'b0;
        vld[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld  = 4'b0;
        data = 24'h0;
    endtask

    // Sends npix beats of a WxH frame with pixel value base+index.
    task automatic run_frame(input int k, input int w, input int h, input int base,
                             input int maxgap, input int npix);
        int seen;
        int r;
        int c;
        int g;
        logic ev;
        seen = 0;
        for (int p = 0; p < npix; p++) begin
            r  = p / w;
            c  = p % w;
            ev = (r % 2 == 1) && (c % 2 == 1) && (c < (w / 2) * 2) && (r < (h / 2) * 2);
            beat(k, 24'(base + p));
            if (wv[k]) seen++;
            chk1("win_vld", wv[k], ev);
            if (ev) chkw("win_data", wd[k], win(base + p - w - 1, base + p - w, base + p - 1, base + p));
            chk1("frame_done", fd[k], (p == w * h - 1));
            chk1("busy", bz[k], (p != w * h - 1));
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            for (int i = 0; i < g; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (wv[k]) seen++;
                chk1("gap_vld", wv[k], 1'b0);
                chk1("gap_done", fd[k], 1'b0);
            end
        end
        if (npix == w * h) chki("win_count", seen, (w / 2) * (h / 2));
    endtask

    initial begin
        rst  = 1'b1;
        vld  = 4'b0;
        data = 24'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk1("rst_vld", wv[k], 1'b0);
            chk1("rst_done", fd[k], 1'b0);
            chk1("rst_busy", bz[k], 1'b0);
            chkw("rst_data", wd[k], 96'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 4x4 back-to-back: windows (0,1,4,5) (2,3,6,7) (8,9,12,13) (10,11,14,15).
        run_frame(0, 4, 4, 0, 0, 16);
        repeat (2) @(negedge clk);
        chk1("idle_vld", wv[0], 1'b0);
        chkw("hold_data", wd[0], win(10, 11, 14, 15));

        // 4x4 with random gaps of 0..3 idle cycles.
        run_frame(0, 4, 4, 0, 3, 16);

        // Abort a frame after pixel 6 (read pending), then a clean frame.
        run_frame(0, 4, 4, 0, 0, 7);
        rst = 1'b1;
        #1;
        chk1("abort_busy", bz[0], 1'b0);
        chk1("abort_vld", wv[0], 1'b0);
        chkw("abort_data", wd[0], 96'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk1("post_rst_vld", wv[0], 1'b0);
            chk1("post_rst_done", fd[0], 1'b0);
        end
        run_frame(0, 4, 4, 0, 0, 16);

        // 5x3: only (0,1,5,6) and (2,3,7,8); frame_done after pixel 14 without a window.
        run_frame(1, 5, 3, 0, 0, 15);

        // Two 4x2 frames back-to-back.
        run_frame(2, 4, 2, 0, 0, 8);
        run_frame(2, 4, 2, 100, 0, 8);

        // 2x2 negative pixels passed bit-exact.
        beat(3, -24'sd1);
        chk1("neg_vld0", wv[3], 1'b0);
        beat(3, -24'sd2);
        chk1("neg_vld1", wv[3], 1'b0);
        beat(3, -24'sd3);
        chk1("neg_vld2", wv[3], 1'b0);
        beat(3, -24'sd4);
        chk1("neg_vld3", wv[3], 1'b1);
        chkw("neg_data", wd[3], 96'hFFFFFC_FFFFFD_FFFFFE_FFFFFF);
        chk1("neg_done", fd[3], 1'b1);
        @(negedge clk);
        chk1("neg_vld_end", wv[3], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
